mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_access.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access pipeline stage: runs a registered single-request data-bus cycle and stalls the pipeline until the bus acknowledges.
// Optional macro LLSC_EN turns on the LL/SC handshake; without it, LL and SC pass through as non-memory ops.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ex_waddr,
  input  logic        ex_we,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_reg2,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we,
  input  logic        wb_LLbit_value,
  output logic [4:0]  mem_waddr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
  output logic        mem_LLbit_we,
  output logic        mem_LLbit_value,
  output logic        stallreq,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;
  localparam logic [7:0] OpLl  = 8'b1111_0000;
  localparam logic [7:0] OpSc  = 8'b1111_1000;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] rdata_q;
  logic [7:0]  op_q;
  logic [1:0]  off_q;

  logic        llbit;
  logic        is_mem;
  logic        req_we;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // WB stage may be writing LLbit this very cycle; its value wins.
  assign llbit = wb_LLbit_we ? wb_LLbit_value : LLbit_i;

  always_comb begin
    is_mem = 1'b0;
    case (ex_aluop)
      OpLb, OpLbu, OpLh, OpLhu, OpLw, OpSb, OpSh, OpSw: is_mem = 1'b1;
`ifdef LLSC_EN
      OpLl: is_mem = 1'b1;
      OpSc: is_mem = llbit;
`endif
      default: is_mem = 1'b0;
    endcase
  end

  // Big-endian lane select and store-data replication.
  always_comb begin
    req_we    = 1'b0;
    req_sel   = 4'b1111;
    req_wdata = ex_reg2;
    case (ex_aluop)
      OpLb, OpLbu: req_sel = 4'b1000 >> ex_mem_addr[1:0];
      OpLh, OpLhu: req_sel = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
      OpSb: begin
        req_we    = 1'b1;
        req_sel   = 4'b1000 >> ex_mem_addr[1:0];
        req_wdata = {4{ex_reg2[7:0]}};
      end
      OpSh: begin
        req_we    = 1'b1;
        req_sel   = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{ex_reg2[15:0]}};
      end
      OpSw, OpSc: req_we = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (is_mem) state_d = StBusy;
      StBusy:  if (bus_ack) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= 4'b0000;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      rdata_q   <= 32'h0;
      op_q      <= 8'h0;
      off_q     <= 2'b00;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && is_mem) begin
        bus_req   <= 1'b1;
        bus_we    <= req_we;
        bus_sel   <= req_sel;
        bus_addr  <= {ex_mem_addr[31:2], 2'b00};
        bus_wdata <= req_wdata;
        op_q      <= ex_aluop;
        off_q     <= ex_mem_addr[1:0];
      end else if (state_q == StBusy && bus_ack) begin
        bus_req <= 1'b0;
        rdata_q <= bus_rdata;
      end
    end
  end

  always_comb begin
    lane_byte = rdata_q[7:0];
    unique case (off_q)
      2'd0: lane_byte = rdata_q[31:24];
      2'd1: lane_byte = rdata_q[23:16];
      2'd2: lane_byte = rdata_q[15:8];
      2'd3: lane_byte = rdata_q[7:0];
      default: ;
    endcase
  end

  assign lane_half = off_q[1] ? rdata_q[15:0] : rdata_q[31:16];

  always_comb begin
    stallreq        = 1'b0;
    mem_waddr       = ex_waddr;
    mem_we          = ex_we;
    mem_wdata       = ex_wdata;
    mem_whilo       = ex_whilo;
    mem_hi          = ex_hi;
    mem_lo          = ex_lo;
    mem_LLbit_we    = 1'b0;
    mem_LLbit_value = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_mem) begin
          stallreq = 1'b1;
          mem_we   = 1'b0;
        end else if (ex_aluop == OpSc) begin
          // SC result: only a failed SC (llbit=0) reaches here when LL/SC is enabled.
          mem_wdata = {31'b0, llbit};
`ifndef LLSC_EN
          mem_we    = 1'b0;
`endif
        end else if (ex_aluop == OpLl) begin
`ifndef LLSC_EN
          mem_we = 1'b0;
`endif
        end
      end
      StBusy: begin
        stallreq = 1'b1;
        mem_we   = 1'b0;
      end
      StDone: begin
        case (op_q)
          OpLb:  mem_wdata = {{24{lane_byte[7]}}, lane_byte};
          OpLbu: mem_wdata = {24'b0, lane_byte};
          OpLh:  mem_wdata = {{16{lane_half[15]}}, lane_half};
          OpLhu: mem_wdata = {16'b0, lane_half};
          OpLw:  mem_wdata = rdata_q;
          OpSb, OpSh, OpSw: mem_we = 1'b0;
`ifdef LLSC_EN
          OpLl: begin
            mem_wdata       = rdata_q;
            mem_LLbit_we    = 1'b1;
            mem_LLbit_value = 1'b1;
          end
          OpSc: begin
            mem_wdata       = 32'h1;
            mem_LLbit_we    = 1'b1;
            mem_LLbit_value = 1'b0;
          end
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
    if (rst) begin
      stallreq        = 1'b0;
      mem_waddr       = 5'd0;
      mem_we          = 1'b0;
      mem_wdata       = 32'h0;
      mem_whilo       = 1'b0;
      mem_hi          = 32'h0;
      mem_lo          = 32'h0;
      mem_LLbit_we    = 1'b0;
      mem_LLbit_value = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against a lane-arithmetic reference model.
module tb_mem_access;

  localparam logic [7:0] OpLb  = 8'b1110_0000;
  localparam logic [7:0] OpLbu = 8'b1110_0100;
  localparam logic [7:0] OpLh  = 8'b1110_0001;
  localparam logic [7:0] OpLhu = 8'b1110_0101;
  localparam logic [7:0] OpLw  = 8'b1110_0011;
  localparam logic [7:0] OpSb  = 8'b1110_1000;
  localparam logic [7:0] OpSh  = 8'b1110_1001;
  localparam logic [7:0] OpSw  = 8'b1110_1011;
  localparam logic [7:0] OpLl  = 8'b1111_0000;
  localparam logic [7:0] OpSc  = 8'b1111_1000;
  localparam logic [7:0] OpNop = 8'h00;
  localparam logic [7:0] OpOr  = 8'h25;
`ifdef LLSC_EN
  localparam bit LlscEn = 1'b1;
`else
  localparam bit LlscEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ex_waddr = '0;
  logic        ex_we = 1'b0;
  logic [31:0] ex_wdata = '0;
  logic        ex_whilo = 1'b0;
  logic [31:0] ex_hi = '0;
  logic [31:0] ex_lo = '0;
  logic [7:0]  ex_aluop = OpNop;
  logic [31:0] ex_mem_addr = '0;
  logic [31:0] ex_reg2 = '0;
  logic        LLbit_i = 1'b0;
  logic        wb_LLbit_we = 1'b0;
  logic        wb_LLbit_value = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [4:0]  mem_waddr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_whilo;
  logic [31:0] mem_hi;
  logic [31:0] mem_lo;
  logic        mem_LLbit_we;
  logic        mem_LLbit_value;
  logic        stallreq;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access dut (
    .clk(clk), .rst(rst),
    .ex_waddr(ex_waddr), .ex_we(ex_we), .ex_wdata(ex_wdata),
    .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .LLbit_i(LLbit_i), .wb_LLbit_we(wb_LLbit_we), .wb_LLbit_value(wb_LLbit_value),
    .mem_waddr(mem_waddr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_LLbit_we(mem_LLbit_we), .mem_LLbit_value(mem_LLbit_value),
    .stallreq(stallreq),
    .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_load(input logic [7:0] op);
    return op inside {OpLb, OpLbu, OpLh, OpLhu, OpLw};
  endfunction

  function automatic bit is_store(input logic [7:0] op);
    return op inside {OpSb, OpSh, OpSw};
  endfunction

  function automatic bit model_mem(input logic [7:0] op, input logic llb);
    return is_load(op) || is_store(op) || (LlscEn && (op == OpLl || (op == OpSc && llb)));
  endfunction

  function automatic int unsigned nbytes(input logic [7:0] op);
    if (op inside {OpLb, OpLbu, OpSb}) return 1;
    if (op inside {OpLh, OpLhu, OpSh}) return 2;
    return 4;
  endfunction

  // Byte offset (big-endian, 0 = MSB) where the accessed lane starts.
  function automatic int unsigned lane_start(input logic [7:0] op, input logic [31:0] addr);
    return int'(addr[1:0]) & ~(nbytes(op) - 1);
  endfunction

  function automatic logic [31:0] exp_sel(input logic [7:0] op, input logic [31:0] addr);
    int unsigned n = nbytes(op);
    return ((32'd1 << n) - 1) << (4 - lane_start(op, addr) - n);
  endfunction

  function automatic logic [31:0] exp_store(input logic [7:0] op, input logic [31:0] r2);
    if (nbytes(op) == 1) return {24'b0, r2[7:0]} * 32'h0101_0101;
    if (nbytes(op) == 2) return {16'b0, r2[15:0]} * 32'h0001_0001;
    return r2;
  endfunction

  function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] addr,
                                          input logic [31:0] rd);
    int unsigned n = nbytes(op);
    logic [31:0] mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 1);
    logic [31:0] v = (rd >> (8 * (4 - lane_start(op, addr) - n))) & mask;
    if ((op == OpLb || op == OpLh) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2,
                       input logic llb, input logic wbwe, input logic wbval,
                       input int unsigned delay, input logic [31:0] rd);
    logic [31:0] wd;
    logic        we;
    logic [4:0]  wa;
    logic        eff;
    logic        exp_we;
    int unsigned stalls;
    @(negedge clk);
    wd = $urandom; we = 1'($urandom); wa = 5'($urandom);
    ex_aluop = op; ex_mem_addr = addr; ex_reg2 = r2;
    ex_we = we; ex_waddr = wa; ex_wdata = wd;
    ex_whilo = 1'($urandom); ex_hi = $urandom; ex_lo = $urandom;
    LLbit_i = llb; wb_LLbit_we = wbwe; wb_LLbit_value = wbval;
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    eff = wbwe ? wbval : llb;
    #1;
    check("waddr", {27'b0, mem_waddr}, {27'b0, wa});
    check("whilo", {31'b0, mem_whilo}, {31'b0, ex_whilo});
    check("hi", mem_hi, ex_hi);
    check("lo", mem_lo, ex_lo);
    if (!model_mem(op, eff)) begin
      exp_we = (op == OpLl || op == OpSc) && !LlscEn ? 1'b0 : we;
      check("nm.stallreq", {31'b0, stallreq}, 32'h0);
      check("nm.bus_req", {31'b0, bus_req}, 32'h0);
      check("nm.mem_we", {31'b0, mem_we}, {31'b0, exp_we});
      check("nm.llbit_we", {31'b0, mem_LLbit_we}, 32'h0);
      if (exp_we) check("nm.wdata", mem_wdata, (op == OpSc) ? 32'h0 : wd);
      return;
    end
    check("idle.stallreq", {31'b0, stallreq}, 32'h1);
    check("idle.mem_we", {31'b0, mem_we}, 32'h0);
    stalls = 1;
    for (int k = 0; k <= int'(delay); k++) begin
      @(negedge clk);
      bus_ack = (k == int'(delay));
      bus_rdata = (k == int'(delay)) ? rd : $urandom;
      #1;
      check("busy.bus_req", {31'b0, bus_req}, 32'h1);
      check("busy.bus_we", {31'b0, bus_we}, {31'b0, (is_store(op) || op == OpSc)});
      check("busy.bus_sel", {28'b0, bus_sel}, exp_sel(op, addr));
      check("busy.bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
      if (bus_we) check("busy.bus_wdata", bus_wdata, exp_store(op, r2));
      check("busy.mem_we", {31'b0, mem_we}, 32'h0);
      check("busy.llbit_we", {31'b0, mem_LLbit_we}, 32'h0);
      if (stallreq) stalls++;
    end
    check("stall_cycles", stalls, delay + 2);
    @(negedge clk);
    bus_ack = 1'($urandom); bus_rdata = $urandom;
    #1;
    check("done.stallreq", {31'b0, stallreq}, 32'h0);
    check("done.bus_req", {31'b0, bus_req}, 32'h0);
    check("done.mem_we", {31'b0, mem_we}, {31'b0, is_store(op) ? 1'b0 : we});
    check("done.llbit_we", {31'b0, mem_LLbit_we}, {31'b0, (op == OpLl || op == OpSc)});
    check("done.llbit_val", {31'b0, mem_LLbit_value}, {31'b0, (op == OpLl)});
    if (!is_store(op))
      check("done.wdata", mem_wdata,
            (op == OpSc) ? 32'h1 : (op == OpLl) ? rd : exp_load(op, addr, rd));
    // Following cycle must be back in IDLE passing a NOP straight through.
    @(negedge clk);
    ex_aluop = OpNop; bus_ack = 1'b0;
    #1;
    check("after.stallreq", {31'b0, stallreq}, 32'h0);
    check("after.wdata", mem_wdata, wd);
    check("after.llbit_we", {31'b0, mem_LLbit_we}, 32'h0);
  endtask

  logic [7:0] ops [12] = '{OpLb, OpLbu, OpLh, OpLhu, OpLw, OpSb, OpSh, OpSw, OpLl, OpSc,
                           OpNop, OpOr};

  initial begin
    // Reset behaviour, with a memory op presented during reset.
    ex_aluop = OpLw; ex_we = 1'b1; ex_waddr = 5'd7; ex_wdata = 32'hDEAD_BEEF;
    ex_whilo = 1'b1; ex_hi = 32'h1111_1111; ex_lo = 32'h2222_2222;
    repeat (2) @(negedge clk);
    #1;
    check("rst.stallreq", {31'b0, stallreq}, 32'h0);
    check("rst.mem_we", {31'b0, mem_we}, 32'h0);
    check("rst.mem_waddr", {27'b0, mem_waddr}, 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    check("rst.mem_whilo", {31'b0, mem_whilo}, 32'h0);
    check("rst.mem_hi", mem_hi, 32'h0);
    check("rst.bus_req", {31'b0, bus_req}, 32'h0);
    check("rst.bus_sel", {28'b0, bus_sel}, 32'h0);
    check("rst.bus_addr", bus_addr, 32'h0);
    check("rst.bus_wdata", bus_wdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; ex_aluop = OpNop;

    // Directed cases from the requirements.
    do_op(OpLw, 32'h100, 32'h0, 1'b0, 1'b0, 1'b0, 2, 32'h1234_5678);
    do_op(OpLb, 32'h103, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0000_00F0);
    do_op(OpLbu, 32'h103, 32'h0, 1'b0, 1'b0, 1'b0, 1, 32'h0000_00F0);
    do_op(OpSh, 32'h202, 32'hAAAA_5678, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    do_op(OpLl, 32'h400, 32'h0, 1'b0, 1'b0, 1'b0, 1, 32'hCAFE_F00D);
    do_op(OpSc, 32'h400, 32'h5555_AAAA, 1'b0, 1'b1, 1'b1, 1, 32'h0);
    do_op(OpSc, 32'h400, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    do_op(OpSc, 32'h404, 32'h1, 1'b1, 1'b1, 1'b0, 0, 32'h0);

    // Reset pulsed mid-BUSY, ack arriving afterwards.
    @(negedge clk);
    ex_aluop = OpLw; ex_mem_addr = 32'h300; ex_we = 1'b1; bus_ack = 1'b0;
    @(negedge clk);
    #1;
    check("rstbusy.bus_req", {31'b0, bus_req}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstbusy.stallreq", {31'b0, stallreq}, 32'h0);
    check("rstbusy.mem_we", {31'b0, mem_we}, 32'h0);
    @(negedge clk);
    rst = 1'b0; ex_aluop = OpNop; ex_we = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    #1;
    check("rstafter.bus_req", {31'b0, bus_req}, 32'h0);
    check("rstafter.stallreq", {31'b0, stallreq}, 32'h0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rstafter2.mem_we", {31'b0, mem_we}, 32'h0);
    check("rstafter2.llbit_we", {31'b0, mem_LLbit_we}, 32'h0);
    check("rstafter2.bus_req", {31'b0, bus_req}, 32'h0);
    check("rstafter2.stallreq", {31'b0, stallreq}, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 200; i++) begin
      do_op(ops[$urandom_range(0, 11)], $urandom, $urandom, 1'($urandom), 1'($urandom),
            1'($urandom), $urandom_range(0, 3), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
